mux_scan_ctrl: RTL and testbench

- Sequential scan controller that sits directly upstream of mux_4x1.
- Drives the mux select lines, waits a programmable settle time per channel, samples the mux output Y, and assembles the four samples into a parallel capture word.
- Supports single-shot and continuous scanning, abort, a completed-scan counter and a change-detect flag.
- Consumers see a 1-cycle done pulse with the captured word.

---
 rtl/mux_scan_ctrl.sv | 115 +++++++++++
 tb/tb_mux_scan_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// Scan controller for a 4:1 mux: steps sel through channels 0..3, waits a
// settle time per channel, samples y_in and publishes a 4-bit capture word.
module mux_scan_ctrl #(
    parameter int SETTLE_CYC = 2,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cont,
    input  logic             abort,
    input  logic             y_in,
    output logic [1:0]       sel,
    output logic             busy,
    output logic             done,
    output logic [3:0]       cap_data,
    output logic             chg,
    output logic [CNT_W-1:0] scan_cnt
);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    localparam logic [3:0] SETTLE = 4'(SETTLE_CYC);

    state_t     state;
    state_t     state_next;
    logic [3:0] dwell;
    logic [3:0] dwell_next;
    logic [1:0] sel_next;
    logic [2:0] shadow;
    logic       sample;
    logic       last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        sel_next   = sel;
        dwell_next = dwell;
        sample     = 1'b0;
        last       = 1'b0;
        unique case (state)
            IDLE: begin
                sel_next   = '0;
                dwell_next = '0;
                if (start && !abort) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (abort) begin
                    state_next = IDLE;
                    sel_next   = '0;
                    dwell_next = '0;
                end else if (dwell != SETTLE) begin
                    dwell_next = dwell + 4'd1;
                end else begin
                    sample     = 1'b1;
                    dwell_next = '0;
                    if (sel == 2'd3) begin
                        last     = 1'b1;
                        sel_next = '0;
                        if (!cont) begin
                            state_next = IDLE;
                        end
                    end else begin
                        sel_next = sel + 2'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                sel_next   = '0;
                dwell_next = '0;
            end
        endcase
    end

    // cap_data itself serves as the previous-capture reference for chg.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel      <= '0;
            dwell    <= '0;
            shadow   <= '0;
            cap_data <= '0;
            done     <= 1'b0;
            chg      <= 1'b0;
            scan_cnt <= '0;
        end else begin
            sel   <= sel_next;
            dwell <= dwell_next;
            done  <= last;
            chg   <= last && ({y_in, shadow} != cap_data);
            if (sample && !last) begin
                shadow[sel] <= y_in;
            end
            if (last) begin
                cap_data <= {y_in, shadow};
                scan_cnt <= scan_cnt + CNT_W'(1);
            end
        end
    end

    assign busy = (state == SCAN);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: directed scenarios plus random traffic, checked
// against a cycle-count model of the scan timeline.
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, cont, abort;
    logic [3:0] mux_i;
    logic       y_in;
    logic [1:0] sel;
    logic       busy, done, chg;
    logic [3:0] cap_data;
    logic [7:0] scan_cnt;

    logic       start0, cont0, abort0;
    logic [3:0] mux0;
    logic       y0;
    logic [1:0] sel0;
    logic       busy0, done0, chg0;
    logic [3:0] cap0;
    logic [1:0] cnt0;

    int compared = 0;
    int mismatched = 0;

    // Reference model (SETTLE_CYC=2): m_t counts cycles since the scan began.
    bit         m_active;
    int         m_t;
    logic [3:0] m_samp, m_cap;
    logic [7:0] m_cnt;
    logic       m_done, m_chg;

    assign y_in = mux_i[sel];
    assign y0   = mux0[sel0];

    mux_scan_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .abort(abort),
        .y_in(y_in), .sel(sel), .busy(busy), .done(done), .cap_data(cap_data),
        .chg(chg), .scan_cnt(scan_cnt)
    );

    mux_scan_ctrl #(.SETTLE_CYC(0), .CNT_W(2)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .cont(cont0), .abort(abort0),
        .y_in(y0), .sel(sel0), .busy(busy0), .done(done0), .cap_data(cap0),
        .chg(chg0), .scan_cnt(cnt0)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_active = 0; m_t = 0; m_samp = '0; m_cap = '0; m_cnt = '0;
        m_done = 0; m_chg = 0;
    endtask

    task automatic tick();
        int ch;
        @(posedge clk);
        m_done = 0;
        m_chg  = 0;
        if (!m_active) begin
            if (start && !abort) begin
                m_active = 1;
                m_t = 0;
            end
        end else if (abort) begin
            m_active = 0;
            m_t = 0;
        end else begin
            m_t++;
            if (m_t % 3 == 0) begin
                ch = m_t / 3 - 1;
                m_samp[ch] = mux_i[ch];
                if (ch == 3) begin
                    m_done = 1;
                    m_chg  = (m_samp != m_cap);
                    m_cap  = m_samp;
                    m_cnt++;
                    m_t = 0;
                    m_active = cont;
                end
            end
        end
        #1;
    endtask

    task automatic reset_all();
        start = 0; cont = 0; abort = 0; mux_i = '0;
        start0 = 0; cont0 = 0; abort0 = 0; mux0 = '0;
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
    endtask

    task automatic test_reset();
        reset_all();
        mux_i = 4'b1010;
        start = 1; tick(); start = 0;
        repeat (12) tick();
        compared++; if (scan_cnt !== 8'd1) begin mismatched++; $display("FAIL rst_pre_cnt got %0d exp 1", scan_cnt); end
        start = 1; tick(); start = 0;
        repeat (4) tick();
        #3 rst = 1;
        #1;
        compared++; if (sel !== 2'd0) begin mismatched++; $display("FAIL rst_sel got %0d exp 0", sel); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rst_busy got %0b exp 0", busy); end
        compared++; if (done !== 1'b0 || chg !== 1'b0) begin mismatched++; $display("FAIL rst_done_chg got %0b%0b exp 00", done, chg); end
        compared++; if (cap_data !== 4'b0000) begin mismatched++; $display("FAIL rst_cap got %b exp 0000", cap_data); end
        compared++; if (scan_cnt !== 8'd0) begin mismatched++; $display("FAIL rst_cnt got %0d exp 0", scan_cnt); end
        compared++; if (sel0 !== 2'd0 || busy0 !== 1'b0 || cnt0 !== 2'd0) begin mismatched++; $display("FAIL rst_dut0 got sel=%0d busy=%0b cnt=%0d exp 0", sel0, busy0, cnt0); end
        @(posedge clk); #1;
        rst = 0;
        model_reset();
        for (int k = 0; k < 15; k++) begin
            tick();
            compared++; if (done !== 1'b0 || busy !== 1'b0) begin mismatched++; $display("FAIL rst_after k=%0d got done=%0b busy=%0b exp 0", k, done, busy); end
        end
    endtask

    task automatic test_single();
        reset_all();
        mux_i = 4'b1010;
        start = 1; tick(); start = 0;
        compared++; if (busy !== 1'b1 || sel !== 2'd0) begin mismatched++; $display("FAIL single_e0 got busy=%0b sel=%0d exp 1/0", busy, sel); end
        for (int k = 1; k <= 12; k++) begin
            logic [1:0] es;
            tick();
            es = (k < 12) ? 2'(k / 3) : 2'd0;
            compared++; if (sel !== es) begin mismatched++; $display("FAIL single_sel k=%0d got %0d exp %0d", k, sel, es); end
            compared++; if (done !== (k == 12)) begin mismatched++; $display("FAIL single_done k=%0d got %0b exp %0b", k, done, k == 12); end
            compared++; if (busy !== (k < 12)) begin mismatched++; $display("FAIL single_busy k=%0d got %0b exp %0b", k, busy, k < 12); end
        end
        compared++; if (cap_data !== 4'b1010) begin mismatched++; $display("FAIL single_cap got %b exp 1010", cap_data); end
        compared++; if (chg !== 1'b1) begin mismatched++; $display("FAIL single_chg got %0b exp 1", chg); end
        compared++; if (scan_cnt !== 8'd1) begin mismatched++; $display("FAIL single_cnt got %0d exp 1", scan_cnt); end
        tick();
        compared++; if (done !== 1'b0 || chg !== 1'b0) begin mismatched++; $display("FAIL single_post got done=%0b chg=%0b exp 0", done, chg); end
    endtask

    task automatic test_cont();
        logic [3:0] ecap [3] = '{4'b1010, 4'b0110, 4'b0110};
        logic       echg [3] = '{1'b1, 1'b1, 1'b0};
        int n = 0;
        reset_all();
        mux_i = 4'b1010;
        cont = 1;
        start = 1; tick(); start = 0;
        for (int k = 1; k <= 60 && n < 3; k++) begin
            tick();
            if (done === 1'b1) begin
                compared++; if (k != 12 * (n + 1)) begin mismatched++; $display("FAIL cont_time scan=%0d got k=%0d exp %0d", n, k, 12 * (n + 1)); end
                compared++; if (cap_data !== ecap[n]) begin mismatched++; $display("FAIL cont_cap scan=%0d got %b exp %b", n, cap_data, ecap[n]); end
                compared++; if (chg !== echg[n]) begin mismatched++; $display("FAIL cont_chg scan=%0d got %0b exp %0b", n, chg, echg[n]); end
                n++;
                if (n == 1) mux_i = 4'b0110;
                if (n == 2) cont = 0;
            end
        end
        compared++; if (n != 3) begin mismatched++; $display("FAIL cont_count got %0d exp 3", n); end
        compared++; if (scan_cnt !== 8'd3) begin mismatched++; $display("FAIL cont_cnt got %0d exp 3", scan_cnt); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL cont_busy got %0b exp 0", busy); end
    endtask

    task automatic test_abort();
        int nd = 0;
        reset_all();
        mux_i = 4'b0101;
        start = 1; tick(); start = 0;
        repeat (12) tick();
        mux_i = 4'b1111;
        start = 1; tick(); start = 0;
        repeat (8) tick();
        abort = 1; tick(); abort = 0;
        compared++; if (busy !== 1'b0 || sel !== 2'd0 || done !== 1'b0) begin mismatched++; $display("FAIL abort_state got busy=%0b sel=%0d done=%0b exp 0", busy, sel, done); end
        compared++; if (cap_data !== 4'b0101) begin mismatched++; $display("FAIL abort_cap got %b exp 0101", cap_data); end
        compared++; if (scan_cnt !== 8'd1) begin mismatched++; $display("FAIL abort_cnt got %0d exp 1", scan_cnt); end
        for (int k = 0; k < 15; k++) begin
            tick();
            if (done === 1'b1) nd++;
        end
        compared++; if (nd != 0) begin mismatched++; $display("FAIL abort_nodone got %0d exp 0", nd); end
        start = 1; tick(); start = 0;
        repeat (12) tick();
        compared++; if (done !== 1'b1 || cap_data !== 4'b1111) begin mismatched++; $display("FAIL abort_fresh got done=%0b cap=%b exp 1/1111", done, cap_data); end
        compared++; if (chg !== 1'b1 || scan_cnt !== 8'd2) begin mismatched++; $display("FAIL abort_fresh_cc got chg=%0b cnt=%0d exp 1/2", chg, scan_cnt); end
        mux_i = 4'b0011;
        start = 1; tick(); start = 0;
        repeat (11) tick();
        abort = 1; tick(); abort = 0;
        compared++; if (done !== 1'b0 || busy !== 1'b0) begin mismatched++; $display("FAIL abort_final got done=%0b busy=%0b exp 0", done, busy); end
        compared++; if (cap_data !== 4'b1111 || scan_cnt !== 8'd2) begin mismatched++; $display("FAIL abort_final_keep got cap=%b cnt=%0d exp 1111/2", cap_data, scan_cnt); end
    endtask

    task automatic test_start_busy();
        int nd = 0;
        reset_all();
        mux_i = 4'($urandom_range(15));
        start = 1; abort = 1; tick(); abort = 0;
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL sb_abort_start got busy=%0b exp 0", busy); end
        tick(); start = 0;
        for (int k = 1; k <= 25; k++) begin
            start = (k < 12 && k % 4 == 1);
            tick();
            if (done === 1'b1) nd++;
        end
        start = 0;
        compared++; if (nd != 1) begin mismatched++; $display("FAIL sb_dones got %0d exp 1", nd); end
        compared++; if (scan_cnt !== 8'd1) begin mismatched++; $display("FAIL sb_cnt got %0d exp 1", scan_cnt); end
        compared++; if (cap_data !== m_cap) begin mismatched++; $display("FAIL sb_cap got %b exp %b", cap_data, m_cap); end
    endtask

    task automatic test_wrap();
        int nd = 0;
        reset_all();
        mux0 = 4'b1100;
        cont0 = 1;
        start0 = 1; tick(); start0 = 0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            compared++; if (sel0 !== 2'(k % 4)) begin mismatched++; $display("FAIL wrap_sel k=%0d got %0d exp %0d", k, sel0, k % 4); end
            compared++; if (done0 !== (k % 4 == 0)) begin mismatched++; $display("FAIL wrap_done k=%0d got %0b exp %0b", k, done0, k % 4 == 0); end
            compared++; if (chg0 !== (k == 4)) begin mismatched++; $display("FAIL wrap_chg k=%0d got %0b exp %0b", k, chg0, k == 4); end
            if (k % 4 == 0) begin
                compared++; if (cnt0 !== 2'(k / 4) || cap0 !== 4'b1100) begin mismatched++; $display("FAIL wrap_cnt k=%0d got cnt=%0d cap=%b exp %0d/1100", k, cnt0, cap0, (k / 4) % 4); end
            end
        end
        repeat (2) tick();
        #3 rst = 1;
        #1;
        compared++; if (cnt0 !== 2'd0 || done0 !== 1'b0 || busy0 !== 1'b0) begin mismatched++; $display("FAIL wrap_rst got cnt=%0d done=%0b busy=%0b exp 0", cnt0, done0, busy0); end
        cont0 = 0;
        @(posedge clk); #1;
        rst = 0;
        model_reset();
        for (int k = 0; k < 8; k++) begin
            tick();
            if (done0 === 1'b1 || busy0 !== 1'b0) nd++;
        end
        compared++; if (nd != 0) begin mismatched++; $display("FAIL wrap_after_rst got %0d bad cycles exp 0", nd); end
    endtask

    task automatic test_random();
        reset_all();
        for (int k = 0; k < 600; k++) begin
            logic [1:0] es;
            start = ($urandom_range(3) == 0);
            if ($urandom_range(7) == 0) cont = ~cont;
            abort = ($urandom_range(39) == 0);
            if ($urandom_range(4) == 0) mux_i = 4'($urandom_range(15));
            tick();
            es = m_active ? 2'(m_t / 3) : 2'd0;
            compared++; if (sel !== es) begin mismatched++; $display("FAIL rand_sel k=%0d got %0d exp %0d", k, sel, es); end
            compared++; if (busy !== m_active) begin mismatched++; $display("FAIL rand_busy k=%0d got %0b exp %0b", k, busy, m_active); end
            compared++; if (done !== m_done) begin mismatched++; $display("FAIL rand_done k=%0d got %0b exp %0b", k, done, m_done); end
            compared++; if (chg !== m_chg) begin mismatched++; $display("FAIL rand_chg k=%0d got %0b exp %0b", k, chg, m_chg); end
            compared++; if (cap_data !== m_cap) begin mismatched++; $display("FAIL rand_cap k=%0d got %b exp %b", k, cap_data, m_cap); end
            compared++; if (scan_cnt !== m_cnt) begin mismatched++; $display("FAIL rand_cnt k=%0d got %0d exp %0d", k, scan_cnt, m_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_cont();
        test_abort();
        test_start_busy();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
